// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Instruction fetch stage with a 2-entry decoupling buffer and
//            single-cycle flush on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] target_address,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        decode_ready
);

  localparam int unsigned        c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_fetch_pc;
  logic [31:0]          w_fetch_pc_nxt;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_cnt_w-1:0]   w_count_nxt;
  logic                 r_pending;

  // Slot 0 is always the head; slot 1 only holds data when count is 2.
  logic [31:0]          r_pc0;
  logic [31:0]          r_ins0;
  logic [31:0]          r_pc1;
  logic [31:0]          r_ins1;

  logic                 w_req;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_wr_head;

  always_comb begin
    w_req          = 1'b0;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_wr_head      = 1'b0;
    w_count_nxt    = r_count;
    w_fetch_pc_nxt = r_fetch_pc;
    w_state_nxt    = r_state;

    // An already-issued request is held through stall until accepted.
    if (r_state == S_FETCH) begin
      w_req = !stall || r_pending;
    end

    if (!pc_src) begin
      w_pop  = (r_count != '0) && decode_ready;
      w_push = w_req && imem_ready && (r_count != c_full);
    end

    w_wr_head = (r_count == '0) || ((r_count == c_one) && w_pop);

    if (pc_src) begin
      w_count_nxt    = '0;
      w_fetch_pc_nxt = target_address;
      w_state_nxt    = S_FLUSH;
    end else begin
      w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      if (w_push) begin
        w_fetch_pc_nxt = r_fetch_pc + 32'd1;
      end
      case (r_state)
        S_IDLE:  w_state_nxt = S_FETCH;
        S_FETCH: if (w_count_nxt == c_full) w_state_nxt = S_FULL;
        S_FULL:  if (w_count_nxt != c_full) w_state_nxt = S_FETCH;
        S_FLUSH: w_state_nxt = S_FETCH;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_count    <= w_count_nxt;
      r_pending  <= w_req && !imem_ready && !pc_src;
    end
  end

  // A push lands after the shift so a simultaneous pop+push keeps order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc0  <= '0;
      r_ins0 <= '0;
      r_pc1  <= '0;
      r_ins1 <= '0;
    end else begin
      if (w_pop) begin
        r_pc0  <= r_pc1;
        r_ins0 <= r_ins1;
      end
      if (w_push) begin
        if (w_wr_head) begin
          r_pc0  <= r_fetch_pc;
          r_ins0 <= imem_rdata;
        end else begin
          r_pc1  <= r_fetch_pc;
          r_ins1 <= imem_rdata;
        end
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_ins0;
  assign instr_pc    = r_pc0;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Randomized self-checking bench for pc_fetch_unit against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] target_address = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready = 1'b0;

  pc_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_src        (pc_src),
    .target_address(target_address),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .decode_ready  (decode_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered {pc, instr} words, next fetch address,
  // cycles remaining before fetching may start, and an outstanding request.
  logic [63:0] m_fifo[$];
  logic [31:0] m_pc;
  int          m_dead;
  bit          m_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_req(input bit st);
    return (m_dead == 0) && (m_fifo.size() < 2) && (!st || m_pending);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_pc      = RESET_PC;
    m_dead    = 1;
    m_pending = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
  endtask

  task automatic check_outputs(input bit st);
    bit r;
    r = m_req(st);
    check("imem_req", 32'(imem_req), 32'(r));
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      check("instr_pc", instr_pc, m_fifo[0][63:32]);
      check("instr", instr, m_fifo[0][31:0]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit src, input logic [31:0] tgt, input bit st,
                       input bit rdy, input logic [31:0] rd, input bit dec);
    bit req;
    bit pop;
    pc_src         = src;
    target_address = tgt;
    stall          = st;
    imem_ready     = rdy;
    imem_rdata     = rd;
    decode_ready   = dec;
    #1;
    check_outputs(st);
    req = m_req(st);
    if (src) begin
      m_pc      = tgt;
      m_fifo.delete();
      m_dead    = 1;
      m_pending = 1'b0;
    end else begin
      pop = (m_fifo.size() != 0) && dec;
      if (pop) void'(m_fifo.pop_front());
      if (req && rdy) begin
        m_fifo.push_back({m_pc, rd});
        m_pc = m_pc + 32'd1;
      end
      m_pending = req && !rdy;
      if (m_dead > 0) m_dead--;
    end
    @(negedge clk);
  endtask

  // Asserts reset asynchronously in the middle of a cycle with a request out.
  task automatic mid_reset(input bit st, input bit dec);
    pc_src       = 1'b0;
    stall        = st;
    imem_ready   = 1'b0;
    decode_ready = dec;
    #1;
    check_outputs(st);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'h0000_0040;
      1:       t = 32'hFFFF_FFFE;
      2:       t = $urandom;
      default: t = 32'($urandom_range(0, 15));
    endcase
    return t;
  endfunction

  initial begin
    #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Free-running fetch with consumer always ready.
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b1);

    // Consumer blocked until the buffer fills, then one pop.
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, $urandom, 1'b0);

    // Request at address 5 held under stall, then accepted.
    cycle(1'b1, 32'd5, 1'b0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, $urandom, 1'b1);

    // Redirect to 0x40 coinciding with an accept at address 7.
    cycle(1'b1, 32'd7, 1'b0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, $urandom, 1'b1);
    cycle(1'b1, 32'h40, 1'b0, 1'b1, $urandom, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b1);

    // Address wrap, then reset while a request is outstanding.
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, $urandom, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, $urandom, 1'b0);
    mid_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0 && imem_req) begin
        mid_reset(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        cycle(($urandom_range(0, 19) == 0), pick_target(),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6),
              $urandom, ($urandom_range(0, 9) < 6));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL have parameter DEPTH, fixed at 2, the fetch-buffer entry count.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 pc_src  input  1  redirect request from the next-PC stage.
REQ-007 target_address  input  32  redirect destination (word address).
REQ-008 stall  input  1  suppresses issue of new memory requests.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  word address of the request.
REQ-011 imem_ready  input  1  memory accept; data valid the same cycle.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 instr_valid  output  1  buffer head holds a valid instruction.
REQ-014 instr  output  32  head instruction word.
REQ-015 instr_pc  output  32  word address of the head instruction.
REQ-016 decode_ready  input  1  decode consumes the head this cycle.

Function
REQ-017 SHALL hold fetch_pc, a 2-entry {pc, instr} FIFO with count 0..2, and state IDLE, FETCH, FULL or FLUSH.
REQ-018 Memory request issue:
- imem_req=1 only in FETCH.
- imem_addr=fetch_pc at all times.
REQ-019 Pending request:
- Once imem_req=1, imem_req and imem_addr SHALL stay stable until imem_ready=1 or a redirect occurs.
- stall does not withdraw a pending request.
REQ-020 Accept (imem_req&imem_ready, no redirect):
- Push {fetch_pc, imem_rdata} at the tail.
- fetch_pc <= fetch_pc+1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-021 Pop on instr_valid&decode_ready:
- instr_valid = (count!=0).
- instr and instr_pc come from head registers, with no combinational path from imem_rdata.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 Transitions:
- IDLE->FETCH unconditionally after one cycle.
- FETCH->FULL when an accept makes count 2 without a pop.
- FETCH holds while stall=1 and no request is pending; imem_req=0 in that case.
- FULL->FETCH when count drops below 2.
REQ-024 Redirect (pc_src=1), highest priority, from any non-reset state:
- fetch_pc <= target_address.
- count <= 0.
- Same-cycle memory response discarded; same-cycle pop ignored.
- Next state FLUSH.
REQ-025 FLUSH SHALL drive imem_req=0 for exactly one cycle, then go to FETCH, or to FLUSH again if pc_src=1.
REQ-026 instr_valid SHALL be 0 in the cycle after a redirect; the first redirected instruction appears no earlier than 2 cycles after pc_src.
REQ-027 SHALL never push when count=2; imem_req=0 in FULL.

Reset
REQ-028 On reset assertion, asynchronously and immediately:
- fetch_pc=RESET_PC, count=0, state=IDLE.
- imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-029 Reset mid-request SHALL drop the pending request with no push; the first request after deassertion uses RESET_PC.

Verification
REQ-030 Reset, imem_ready=1, decode_ready=1: imem_addr 0,1,2,... on consecutive cycles; instr_pc tracks with 1-cycle lag; first imem_req=1 two cycles after reset release.
REQ-031 decode_ready=0, imem_ready=1: two pushes, state FULL, imem_req=0, imem_addr=2; decode_ready=1 for one cycle -> head instr_pc=1, imem_req=1 next cycle.
REQ-032 Pending request at addr 5 with imem_ready=0 for 3 cycles and stall=1: imem_req and imem_addr=5 stay stable; accept on cycle 4 pushes pc=5.
REQ-033 pc_src=1, target_address=32'h40, simultaneous with imem_ready=1 at addr 7: addr-7 data discarded; instr_valid=0 next cycle; one FLUSH cycle with imem_req=0; then imem_addr=32'h40.
REQ-034 fetch_pc=32'hFFFF_FFFF accepted -> next imem_addr=0; reset asserted mid-request -> imem_req=0 immediately; after release first imem_addr=RESET_PC.
